alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits, legal values 8, 16, 32.
REQ-002 SHALL use localparam SHW = clog2(WIDTH) as the shift-amount width, taken from DATA_B[SHW-1:0].
REQ-003 SHALL have port CLK, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port IN_VALID, input, 1 bit: operands and opcode are valid.
REQ-006 SHALL have port IN_READY, output, 1 bit: the block accepts an operation this cycle.
REQ-007 SHALL have port DATA_A, input, WIDTH bits: operand A.
REQ-008 SHALL have port DATA_B, input, WIDTH bits: operand B, or the shift amount in its low SHW bits.
REQ-009 SHALL have port S_ALU, input, 4 bits: opcode.
REQ-010 SHALL have port OUT_VALID, output, 1 bit: ALU_OUT and FLAG_OUT hold a result.
REQ-011 SHALL have port OUT_READY, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port ALU_OUT, output, WIDTH bits: registered result.
REQ-013 SHALL have port FLAG_OUT, output, 4 bits: registered flags {S,Z,C,V}.

Function
REQ-014 SHALL decode these opcodes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 1000, SLR (rotate left) 1001, SRL 1010, SRA 1011, MUL 1100, NON 1111.
REQ-015 SHALL, for any other opcode, produce result 0 and flags S=0, Z=1, C=0, V=0.
REQ-016 SHALL accept an operation only on a cycle with IN_VALID=1 and IN_READY=1, latching DATA_A, DATA_B and S_ALU.
REQ-017 SHALL implement an FSM with states IDLE, BUSY and DONE; the state after reset is IDLE.
REQ-018 SHALL move IDLE->DONE on acceptance of a non-MUL operation; ALU_OUT, FLAG_OUT and OUT_VALID=1 are valid one edge after acceptance.
REQ-019 SHALL move IDLE->BUSY on acceptance of MUL, then run an unsigned shift-add for exactly WIDTH cycles, then move BUSY->DONE; OUT_VALID rises WIDTH+1 edges after acceptance.
REQ-020 SHALL, in DONE with OUT_READY=1 and no new acceptance, move to IDLE and drop OUT_VALID on that edge.
REQ-021 SHALL drive IN_READY = (state==IDLE) | (state==DONE & OUT_READY); an accept in DONE gives back-to-back results with no bubble.
REQ-022 SHALL hold ALU_OUT, FLAG_OUT and OUT_VALID stable while OUT_VALID=1 and OUT_READY=0.
REQ-023 SHALL drive IN_READY=0 in BUSY and ignore IN_VALID there.
REQ-024 SHALL compute ADD/SUB in WIDTH+1 bits; C = carry out for ADD, C = borrow (A<B unsigned) for SUB.
REQ-025 SHALL set V for ADD when A[MSB]==B[MSB]!=R[MSB], for SUB when A[MSB]!=B[MSB] and R[MSB]!=A[MSB], and V=0 for all other opcodes.
REQ-026 SHALL, for shifts with amount n>0, set C to the last bit shifted out: A[WIDTH-n] for SLL/SLR, A[n-1] for SRL/SRA; n=0 gives result A and C=0.
REQ-027 SHALL make SRA sign-fill and SLR rotate within WIDTH bits.
REQ-028 SHALL set ALU_OUT = low WIDTH bits of A*B for MUL, and C = 1 iff the upper WIDTH product bits are nonzero.
REQ-029 SHALL set S = R[MSB] and Z = (R==0) for every opcode except NON; AND/OR/XOR give C=0.
REQ-030 SHALL, for NON, produce ALU_OUT=0 with FLAG_OUT keeping its previous value, and still complete the handshake with OUT_VALID.

Reset
REQ-031 SHALL, while RST=1, force state IDLE, OUT_VALID=0, ALU_OUT=0, FLAG_OUT=4'b0000, clear the MUL accumulator/counter, and drive IN_READY=0.
REQ-032 SHALL, on RST asserted mid-MUL or in DONE, discard the operation; no OUT_VALID results from it after release.
REQ-033 SHALL drive IN_READY=1 on the first cycle after RST deasserts.

Verification
REQ-034 SHALL cover ADD with A=0x7FFF, B=0x0001 -> ALU_OUT=0x8000, FLAG_OUT=1001, OUT_VALID one edge after accept.
REQ-035 SHALL cover SUB with A=0x0000, B=0x0001 -> ALU_OUT=0xFFFF, FLAG_OUT=1010; then NON -> ALU_OUT=0x0000, FLAG_OUT=1010.
REQ-036 SHALL cover SRA with A=0x8001, n=1 -> 0xC000, C=1; SLR with A=0x8001, n=4 -> 0x0018, C=0; SLL with n=0 -> A unchanged, C=0.
REQ-037 SHALL cover MUL with A=0x0100, B=0x0101 -> ALU_OUT=0x0100, FLAG_OUT=0010, OUT_VALID exactly 17 edges after accept, IN_READY=0 throughout BUSY.
REQ-038 SHALL cover OUT_READY=0 for 3 cycles in DONE -> outputs stable, IN_READY=0; then OUT_READY=1 with IN_VALID=1 -> new accept the same cycle, next result on the following edge.
REQ-039 SHALL cover RST pulsed on cycle 5 of a MUL -> all outputs 0, no later OUT_VALID, IN_READY=1 after release.

Source files
------------

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle logic/arith/shift ops, WIDTH-cycle shift-add multiply.
// Results and flags are registered and held until the consumer takes them.
module alu_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] DATA_A,
    input  logic [WIDTH-1:0] DATA_B,
    input  logic [3:0]       S_ALU,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic [3:0]       FLAG_OUT
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned PW  = 2 * WIDTH;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SLR = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam logic [3:0] OP_NON = 4'b1111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   alu_out_q, alu_out_d;
    logic [3:0]         flag_out_q, flag_out_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               is_mul;
    logic               mul_last;
    logic [PW-1:0]      mul_sum;
    logic [SHW-1:0]     n, n_neg, n_m1;
    logic [WIDTH:0]     add_w, sub_w;
    logic [PW-1:0]      rot_w;
    logic [WIDTH-1:0]   res;
    logic               c_f, v_f;
    logic [3:0]         alu_flags;

    assign IN_READY  = !RST && (state_q == IDLE || (state_q == DONE && OUT_READY));
    assign accept    = IN_VALID && IN_READY;
    assign is_mul    = (S_ALU == OP_MUL);
    assign OUT_VALID = out_valid_q;
    assign ALU_OUT   = alu_out_q;
    assign FLAG_OUT  = flag_out_q;

    // One partial product per BUSY cycle, selected by multiplier bit cnt_q
    assign mul_last = (cnt_q == SHW'(WIDTH - 1));
    assign mul_sum  = acc_q + (b_q[cnt_q] ? (PW'(a_q) << cnt_q) : '0);

    // n_neg = WIDTH-n (last bit out on left shifts), n_m1 = n-1 (right shifts)
    assign n     = DATA_B[SHW-1:0];
    assign n_neg = ~n + SHW'(1);
    assign n_m1  = n - SHW'(1);
    assign add_w = {1'b0, DATA_A} + {1'b0, DATA_B};
    assign sub_w = {1'b0, DATA_A} - {1'b0, DATA_B};
    assign rot_w = {DATA_A, DATA_A} << n;

    always_comb begin
        res = '0;
        c_f = 1'b0;
        v_f = 1'b0;
        case (S_ALU)
            OP_ADD: begin
                res = add_w[WIDTH-1:0];
                c_f = add_w[WIDTH];
                v_f = (DATA_A[MSB] == DATA_B[MSB]) && (add_w[MSB] != DATA_A[MSB]);
            end
            OP_SUB: begin
                res = sub_w[WIDTH-1:0];
                c_f = sub_w[WIDTH];
                v_f = (DATA_A[MSB] != DATA_B[MSB]) && (sub_w[MSB] != DATA_A[MSB]);
            end
            OP_AND: res = DATA_A & DATA_B;
            OP_OR:  res = DATA_A | DATA_B;
            OP_XOR: res = DATA_A ^ DATA_B;
            OP_SLL: begin
                res = DATA_A << n;
                c_f = (n != '0) && DATA_A[n_neg];
            end
            OP_SLR: begin
                res = rot_w[PW-1:WIDTH];
                c_f = (n != '0) && DATA_A[n_neg];
            end
            OP_SRL: begin
                res = DATA_A >> n;
                c_f = (n != '0) && DATA_A[n_m1];
            end
            OP_SRA: begin
                res = WIDTH'($signed(DATA_A) >>> n);
                c_f = (n != '0) && DATA_A[n_m1];
            end
            default: ;
        endcase
        alu_flags = {res[MSB], (res == '0), c_f, v_f};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = is_mul ? BUSY : DONE;
            BUSY: if (mul_last) state_d = DONE;
            DONE: begin
                if (accept)         state_d = is_mul ? BUSY : DONE;
                else if (OUT_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NON clears the result but keeps the previous flags
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        alu_out_d  = alu_out_q;
        flag_out_d = flag_out_q;
        if (accept) begin
            a_d   = DATA_A;
            b_d   = DATA_B;
            acc_d = '0;
            cnt_d = '0;
            if (S_ALU == OP_NON) begin
                alu_out_d = '0;
            end else if (!is_mul) begin
                alu_out_d  = res;
                flag_out_d = alu_flags;
            end
        end else if (state_q == BUSY) begin
            acc_d = mul_sum;
            cnt_d = cnt_q + SHW'(1);
            if (mul_last) begin
                alu_out_d  = mul_sum[WIDTH-1:0];
                flag_out_d = {mul_sum[MSB], (mul_sum[WIDTH-1:0] == '0),
                              (mul_sum[PW-1:WIDTH] != '0), 1'b0};
            end
        end
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            alu_out_q   <= '0;
            flag_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            alu_out_q   <= alu_out_d;
            flag_out_q  <= flag_out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=16): vector table for single-cycle ops,
// hand-written sequences for multiply latency, backpressure and reset.
module tb_alu_pipe;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned NVEC  = 18;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  data_a;
    logic [WIDTH-1:0]  data_b;
    logic [3:0]        s_alu;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  alu_out;
    logic [3:0]        flag_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .CLK      (clk),
        .RST      (rst),
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .DATA_A   (data_a),
        .DATA_B   (data_b),
        .S_ALU    (s_alu),
        .OUT_VALID(out_valid),
        .OUT_READY(out_ready),
        .ALU_OUT  (alu_out),
        .FLAG_OUT (flag_out)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flg;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_flg(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_dat(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        s_alu  = op;
        data_a = a;
        data_b = b;
    endtask

    // Single-cycle op from IDLE: result must be valid right after the accepting edge
    task automatic run_vec(input int i);
        drive(vecs[i].op, vecs[i].a, vecs[i].b);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk_bit($sformatf("vec%0d in_ready", i), in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk_bit($sformatf("vec%0d out_valid", i), out_valid, 1'b1);
        chk_dat($sformatf("vec%0d alu_out", i), alu_out, vecs[i].res);
        chk_flg($sformatf("vec%0d flag_out", i), flag_out, vecs[i].flg);
        tick();
    endtask

    // MUL from IDLE with OUT_READY=0; junk IN_VALID during BUSY must be ignored.
    // Ends in DONE with the result presented.
    task automatic run_mul(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] res, input logic [3:0] flg);
        logic bad;
        drive(4'b1100, a, b);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        drive(4'b0000, 16'h0001, 16'h0001);
        bad = 1'b0;
        for (int k = 1; k <= int'(WIDTH); k++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk_bit({name, " busy quiet"}, bad, 1'b0);
        chk_bit({name, " out_valid at 17th edge"}, out_valid, 1'b1);
        chk_dat({name, " alu_out"}, alu_out, res);
        chk_flg({name, " flag_out"}, flag_out, flg);
    endtask

    initial begin
        logic seen;

        vecs[0]  = '{4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001};
        vecs[1]  = '{4'b0001, 16'h0000, 16'h0001, 16'hFFFF, 4'b1010};
        vecs[2]  = '{4'b1111, 16'h1234, 16'h5678, 16'h0000, 4'b1010};
        vecs[3]  = '{4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110};
        vecs[4]  = '{4'b0001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001};
        vecs[5]  = '{4'b0010, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
        vecs[6]  = '{4'b0011, 16'h1200, 16'h0034, 16'h1234, 4'b0000};
        vecs[7]  = '{4'b0100, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100};
        vecs[8]  = '{4'b1011, 16'h8001, 16'h0001, 16'hC000, 4'b1010};
        vecs[9]  = '{4'b1001, 16'h8001, 16'h0004, 16'h0018, 4'b0000};
        vecs[10] = '{4'b1000, 16'h1234, 16'h0010, 16'h1234, 4'b0000};
        vecs[11] = '{4'b1000, 16'h8001, 16'h0001, 16'h0002, 4'b0010};
        vecs[12] = '{4'b1010, 16'h8001, 16'h0001, 16'h4000, 4'b0010};
        vecs[13] = '{4'b1010, 16'h00F0, 16'h0004, 16'h000F, 4'b0000};
        vecs[14] = '{4'b0101, 16'h1234, 16'h0001, 16'h0000, 4'b0100};
        vecs[15] = '{4'b1011, 16'h7FFF, 16'h000F, 16'h0000, 4'b0110};
        vecs[16] = '{4'b1001, 16'h1234, 16'h0008, 16'h3412, 4'b0000};
        vecs[17] = '{4'b1111, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(4'b0000, 16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        chk_bit("reset out_valid", out_valid, 1'b0);
        chk_dat("reset alu_out", alu_out, 16'h0000);
        chk_flg("reset flag_out", flag_out, 4'b0000);
        chk_bit("reset in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk_bit("post-reset in_ready", in_ready, 1'b1);

        for (int i = 0; i < int'(NVEC); i++) run_vec(i);

        // MUL followed by 3 cycles of backpressure, then a back-to-back accept
        run_mul("mul0", 16'h0100, 16'h0101, 16'h0100, 4'b0010);
        drive(4'b0000, 16'h0003, 16'h0004);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_bit($sformatf("hold%0d out_valid", k), out_valid, 1'b1);
            chk_dat($sformatf("hold%0d alu_out", k), alu_out, 16'h0100);
            chk_flg($sformatf("hold%0d flag_out", k), flag_out, 4'b0010);
            chk_bit($sformatf("hold%0d in_ready", k), in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk_bit("b2b in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk_bit("b2b out_valid", out_valid, 1'b1);
        chk_dat("b2b alu_out", alu_out, 16'h0007);
        chk_flg("b2b flag_out", flag_out, 4'b0000);
        tick();
        chk_bit("drain out_valid", out_valid, 1'b0);

        run_mul("mul1", 16'h0003, 16'h0005, 16'h000F, 4'b0000);
        out_ready = 1'b1;
        tick();
        run_mul("mul2", 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010);
        out_ready = 1'b1;
        tick();
        chk_bit("mul2 drain out_valid", out_valid, 1'b0);

        // Reset on cycle 5 of a multiply
        drive(4'b1100, 16'hFFFF, 16'hFFFF);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk_bit("midmul rst out_valid", out_valid, 1'b0);
        chk_dat("midmul rst alu_out", alu_out, 16'h0000);
        chk_flg("midmul rst flag_out", flag_out, 4'b0000);
        chk_bit("midmul rst in_ready", in_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk_bit("midmul release in_ready", in_ready, 1'b1);
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk_bit("midmul no late out_valid", seen, 1'b0);

        // Reset while a result is held in DONE
        drive(4'b0000, 16'h7FFF, 16'h0001);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk_bit("done out_valid", out_valid, 1'b1);
        chk_dat("done alu_out", alu_out, 16'h8000);
        rst = 1'b1;
        #1;
        chk_bit("done rst out_valid", out_valid, 1'b0);
        chk_dat("done rst alu_out", alu_out, 16'h0000);
        tick();
        rst = 1'b0;
        #1;
        chk_bit("done release in_ready", in_ready, 1'b1);
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk_bit("done no late out_valid", seen, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
